fc_layer_sequencer: RTL and testbench
=====================================

// Module: fc_layer_sequencer
// PURPOSE
//  Sequences the 4-lane MAC accumulator through one fully-connected layer: for each output neuron it
//  flushes the accumulator, streams packed int8 feature/weight words from sync-read memories, adds the
//  bias, then writes a requantised int8 result (optional ReLU) to the output buffer.
//  Sits between the layer memories and the MAC accumulator; one instance per FC layer of the MNIST net.
// PARAMETERS
//  IN_LEN   784  input features per neuron (>=1); WORDS = ceil(IN_LEN/4) packed 4x8-bit words
//  OUT_LEN  10   output neurons (>=1)
//  MAC_LAT  2    cycles from last lane-valid to final accumulate inside the MAC array
//  SHIFT    7    arithmetic right shift applied to the 26-bit accumulator before saturation
//  RELU     1    1: clamp negatives to 0 before shift; 0: signed output
//  FA_W     10   feature/weight-word address width; WA_W 14 weight address width; OA_W 4 bias/output addr width
// PORTS
//  clk           in   1      clock, all logic on rising edge
//  rst           in   1      asynchronous active-high reset
//  start         in   1      pulse in IDLE starts a layer; ignored while busy
//  busy          out  1      high from cycle after accepted start until done pulse
//  done          out  1      one-cycle pulse after last output write
//  feat_addr     out  FA_W   feature word read address (data valid next cycle)
//  feat_data     in   32     4 packed int8 features, lane0 = [7:0]
//  wgt_addr      out  WA_W   weight word read address = neuron*WORDS + word
//  wgt_data      in   32     4 packed int8 weights, lane-aligned with feat_data
//  bias_addr     out  OA_W   bias read address = current neuron
//  bias_data     in   8      signed int8 bias, valid next cycle
//  mac_en        out  1      accumulator enable
//  mac_flush     out  1      clear accumulator
//  mac_bias_add  out  1      add bias, accumulator raises mac_done next cycle
//  mac_valid     out  4      per-lane valid for mac_feature/mac_weight
//  mac_feature   out  32     registered feat_data
//  mac_weight    out  32     registered wgt_data
//  mac_bias      out  8      registered bias_data
//  mac_result    in   26     signed accumulator value, valid when mac_done
//  mac_done      in   1      accumulator final for this neuron
//  out_we        out  1      output write strobe, one cycle per neuron
//  out_addr      out  OA_W   neuron index
//  out_data      out  8      requantised signed int8 result
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, neuron/word counters 0. Reset mid-layer aborts immediately; no write
//   and no done pulse; next start restarts from neuron 0.
//  States: IDLE -start-> FLUSH(1 cyc: mac_en=1,mac_flush=1, bias_addr=neuron) -> FEED(WORDS cyc)
//   -> DRAIN(MAC_LAT+1 cyc) -> BIAS(1 cyc) -> WAIT(until mac_done) -> WRITE(1 cyc)
//   -> FLUSH if neuron<OUT_LEN-1 (neuron++), else FINISH(1 cyc: done=1) -> IDLE.
//  mac_en=1 in every non-IDLE state. FEED issues word addresses 0..WORDS-1, one per cycle, no stalls.
//  Read data registered: mac_valid/mac_feature/mac_weight for word k appear 2 cycles after its address
//   (1 memory + 1 register); mac_valid=0 on all other cycles. DRAIN covers this offset.
//  Last word mask: r=IN_LEN%4; r==0 -> 4'hF, else lanes [r-1:0] only (r=2 -> 4'b0011).
//  BIAS: mac_bias_add=1 with mac_bias holding bias_data of current neuron; mac_valid=0 during it.
//  WAIT: captures mac_result on the cycle mac_done=1; no timeout.
//  Requant: v=mac_result; if RELU and v<0 -> 0; v=v>>>SHIFT; saturate to [-128,127] (RELU: [0,127]).
//  WRITE: out_we=1, out_addr=neuron, out_data=requantised v; out_data holds until next write.
//  Total cycles/neuron = 1+WORDS+MAC_LAT+1+1+(mac_done delay, 1)+1.
//  start during busy or same cycle as done: ignored (a start is accepted only in IDLE).
// TESTING
//  IN_LEN=8,OUT_LEN=2,SHIFT=0: features all 1, weights all 2, bias 3 -> out 19 at addr 0 and 1, then done.
//  IN_LEN=6: last word 4'b0011; lanes 2,3 carry 0x7F garbage -> garbage excluded, out = exact 6-term sum+bias.
//  SHIFT=0: sum 300 -> out_data 127; RELU=1 sum -50 -> 0; RELU=0 sum -300 -> -128 (0x80).
//  SHIFT=7, sum 1000 -> out 7 (1000>>>7); RELU=0, sum -1000 -> -8.
//  Assert rst during FEED of neuron 1 -> all outputs 0 next cycle, no done; restart gives correct full layer.
//  Pulse start while busy and in done cycle -> no restart, exactly OUT_LEN writes, one done pulse.

Source files
------------

// File: rtl/fc_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : fc_layer_sequencer
// Brief   : Drives a 4-lane MAC accumulator through one fully-connected layer
//           and writes a requantised int8 result per output neuron.
// Rev     : 1.0  initial release
// ============================================================================
module fc_layer_sequencer #(
    parameter int IN_LEN  = 784,
    parameter int OUT_LEN = 10,
    parameter int MAC_LAT = 2,
    parameter int SHIFT   = 7,
    parameter int RELU    = 1,
    parameter int FA_W    = 10,
    parameter int WA_W    = 14,
    parameter int OA_W    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [FA_W-1:0] feat_addr,
    input  logic [31:0]     feat_data,
    output logic [WA_W-1:0] wgt_addr,
    input  logic [31:0]     wgt_data,
    output logic [OA_W-1:0] bias_addr,
    input  logic [7:0]      bias_data,
    output logic            mac_en,
    output logic            mac_flush,
    output logic            mac_bias_add,
    output logic [3:0]      mac_valid,
    output logic [31:0]     mac_feature,
    output logic [31:0]     mac_weight,
    output logic [7:0]      mac_bias,
    input  logic [25:0]     mac_result,
    input  logic            mac_done,
    output logic            out_we,
    output logic [OA_W-1:0] out_addr,
    output logic [7:0]      out_data
);

    localparam int         c_WORDS     = (IN_LEN + 3) / 4;
    localparam int         c_REM       = IN_LEN % 4;
    localparam logic [3:0] c_LAST_MASK = (c_REM == 0) ? 4'hF : 4'((1 << c_REM) - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FLUSH  = 3'd1,
        S_FEED   = 3'd2,
        S_DRAIN  = 3'd3,
        S_BIAS   = 3'd4,
        S_WAIT   = 3'd5,
        S_WRITE  = 3'd6,
        S_FINISH = 3'd7
    } state_t;

    state_t          state_q, state_d;
    logic [OA_W-1:0] neuron_q, neuron_d;
    logic [FA_W-1:0] word_q, word_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [3:0]      lane_q, lane_d;

    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [FA_W-1:0] feat_addr_q, feat_addr_d;
    logic [WA_W-1:0] wgt_addr_q, wgt_addr_d;
    logic [OA_W-1:0] bias_addr_q, bias_addr_d;
    logic            mac_en_q, mac_en_d;
    logic            mac_flush_q, mac_flush_d;
    logic            mac_bias_add_q, mac_bias_add_d;
    logic [3:0]      mac_valid_q, mac_valid_d;
    logic [31:0]     mac_feature_q, mac_feature_d;
    logic [31:0]     mac_weight_q, mac_weight_d;
    logic [7:0]      mac_bias_q, mac_bias_d;
    logic            out_we_q, out_we_d;
    logic [OA_W-1:0] out_addr_q, out_addr_d;
    logic [7:0]      out_data_q, out_data_d;

    // ReLU clamps before the shift so the saturation floor becomes 0.
    function automatic logic [7:0] requant(input logic [25:0] acc);
        logic signed [25:0] v;
        logic [7:0]         r;
        v = $signed(acc);
        if (RELU != 0 && v < 0) begin
            v = '0;
        end
        v = v >>> SHIFT;
        if (v > 26'sd127) begin
            r = 8'h7F;
        end else if (v < -26'sd128) begin
            r = 8'h80;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        neuron_d = neuron_q;
        word_d   = word_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_FLUSH;
                    neuron_d = '0;
                end
            end
            S_FLUSH: begin
                state_d = S_FEED;
                word_d  = '0;
            end
            S_FEED: begin
                if (word_q == FA_W'(c_WORDS - 1)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    word_d = word_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == 8'(MAC_LAT)) begin
                    state_d = S_BIAS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BIAS:  state_d = S_WAIT;
            S_WAIT: begin
                if (mac_done) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (neuron_q == OA_W'(OUT_LEN - 1)) begin
                    state_d = S_FINISH;
                end else begin
                    state_d  = S_FLUSH;
                    neuron_d = neuron_q + 1'b1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Lane mask travels two stages so it lines up with memory latency plus the data register.
    always_comb begin
        lane_d = 4'h0;
        if (state_q == S_FEED) begin
            lane_d = (word_q == FA_W'(c_WORDS - 1)) ? c_LAST_MASK : 4'hF;
        end
        mac_valid_d    = lane_q;
        mac_feature_d  = feat_data;
        mac_weight_d   = wgt_data;
        mac_bias_d     = bias_data;

        busy_d         = (state_d != S_IDLE);
        mac_en_d       = (state_d != S_IDLE);
        done_d         = (state_d == S_FINISH);
        mac_flush_d    = (state_d == S_FLUSH);
        mac_bias_add_d = (state_d == S_BIAS);
        bias_addr_d    = (state_d == S_IDLE) ? '0 : neuron_d;
        feat_addr_d    = (state_d == S_FEED) ? word_d : '0;
        wgt_addr_d     = (state_d == S_FEED)
                       ? (WA_W'(neuron_d) * WA_W'(c_WORDS) + WA_W'(word_d)) : '0;

        out_we_d       = (state_d == S_WRITE);
        out_addr_d     = out_addr_q;
        out_data_d     = out_data_q;
        if (state_d == S_WRITE) begin
            out_addr_d = neuron_d;
            out_data_d = requant(mac_result);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            neuron_q       <= '0;
            word_q         <= '0;
            cnt_q          <= '0;
            lane_q         <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            feat_addr_q    <= '0;
            wgt_addr_q     <= '0;
            bias_addr_q    <= '0;
            mac_en_q       <= 1'b0;
            mac_flush_q    <= 1'b0;
            mac_bias_add_q <= 1'b0;
            mac_valid_q    <= '0;
            mac_feature_q  <= '0;
            mac_weight_q   <= '0;
            mac_bias_q     <= '0;
            out_we_q       <= 1'b0;
            out_addr_q     <= '0;
            out_data_q     <= '0;
        end else begin
            state_q        <= state_d;
            neuron_q       <= neuron_d;
            word_q         <= word_d;
            cnt_q          <= cnt_d;
            lane_q         <= lane_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            feat_addr_q    <= feat_addr_d;
            wgt_addr_q     <= wgt_addr_d;
            bias_addr_q    <= bias_addr_d;
            mac_en_q       <= mac_en_d;
            mac_flush_q    <= mac_flush_d;
            mac_bias_add_q <= mac_bias_add_d;
            mac_valid_q    <= mac_valid_d;
            mac_feature_q  <= mac_feature_d;
            mac_weight_q   <= mac_weight_d;
            mac_bias_q     <= mac_bias_d;
            out_we_q       <= out_we_d;
            out_addr_q     <= out_addr_d;
            out_data_q     <= out_data_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign feat_addr    = feat_addr_q;
    assign wgt_addr     = wgt_addr_q;
    assign bias_addr    = bias_addr_q;
    assign mac_en       = mac_en_q;
    assign mac_flush    = mac_flush_q;
    assign mac_bias_add = mac_bias_add_q;
    assign mac_valid    = mac_valid_q;
    assign mac_feature  = mac_feature_q;
    assign mac_weight   = mac_weight_q;
    assign mac_bias     = mac_bias_q;
    assign out_we       = out_we_q;
    assign out_addr     = out_addr_q;
    assign out_data     = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_fc_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_fc_layer_sequencer
// Brief   : Three differently configured sequencers against memory/MAC models
//           and a sum-of-products reference.
// Rev     : 1.0  initial release
// ============================================================================
module tb_fc_layer_sequencer;

    localparam int c_N = 3;

    function automatic int cfg_in(input int k);    return (k == 0) ? 8 : (k == 1) ? 6 : 5; endfunction
    function automatic int cfg_out(input int k);   return (k == 1) ? 3 : 2;                endfunction
    function automatic int cfg_lat(input int k);   return (k == 2) ? 3 : 2;                endfunction
    function automatic int cfg_shift(input int k); return (k == 2) ? 7 : 0;                endfunction
    function automatic int cfg_relu(input int k);  return (k == 0) ? 1 : 0;                endfunction
    function automatic int cfg_words(input int k); return (cfg_in(k) + 3) / 4;             endfunction

    logic clk = 1'b0;
    logic rst;
    logic start;
    always #5 clk = ~clk;

    logic        busy [c_N], done [c_N], mac_en [c_N], mac_flush [c_N], mac_bias_add [c_N], out_we [c_N];
    logic [9:0]  feat_addr [c_N];
    logic [13:0] wgt_addr [c_N];
    logic [3:0]  bias_addr [c_N], out_addr [c_N], mac_valid [c_N];
    logic [31:0] mac_feature [c_N], mac_weight [c_N];
    logic [7:0]  mac_bias [c_N], out_data [c_N];

    logic [31:0] fmem [c_N][16];
    logic [31:0] wmem [c_N][64];
    logic [7:0]  bmem [c_N][16];
    logic        ovr_en;
    logic [25:0] ovr_val;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int wr_cnt   [c_N] = '{0, 0, 0};
    int done_cnt [c_N] = '{0, 0, 0};
    logic [7:0] wr_data [c_N][256];
    logic [3:0] wr_addr [c_N][256];
    int         wr_cyc  [c_N][256];

    function automatic int byte_at(input logic [31:0] w, input int l);
        logic [7:0] b;
        b = w[l*8 +: 8];
        return int'($signed(b));
    endfunction

    function automatic int lane_sum(input logic [3:0] v, input logic [31:0] f, input logic [31:0] w);
        int s = 0;
        for (int l = 0; l < 4; l++) if (v[l]) s += byte_at(f, l) * byte_at(w, l);
        return s;
    endfunction

    for (genvar g = 0; g < c_N; g++) begin : g_dut
        logic [31:0]        feat_data, wgt_data;
        logic [7:0]         bias_data;
        logic signed [25:0] acc;
        logic               mac_done;
        logic [25:0]        mac_result;
        assign mac_result = ovr_en ? ovr_val : acc;

        fc_layer_sequencer #(
            .IN_LEN(cfg_in(g)), .OUT_LEN(cfg_out(g)), .MAC_LAT(cfg_lat(g)),
            .SHIFT(cfg_shift(g)), .RELU(cfg_relu(g)), .FA_W(10), .WA_W(14), .OA_W(4)
        ) u_dut (
            .clk(clk), .rst(rst), .start(start), .busy(busy[g]), .done(done[g]),
            .feat_addr(feat_addr[g]), .feat_data(feat_data),
            .wgt_addr(wgt_addr[g]), .wgt_data(wgt_data),
            .bias_addr(bias_addr[g]), .bias_data(bias_data),
            .mac_en(mac_en[g]), .mac_flush(mac_flush[g]), .mac_bias_add(mac_bias_add[g]),
            .mac_valid(mac_valid[g]), .mac_feature(mac_feature[g]), .mac_weight(mac_weight[g]),
            .mac_bias(mac_bias[g]), .mac_result(mac_result), .mac_done(mac_done),
            .out_we(out_we[g]), .out_addr(out_addr[g]), .out_data(out_data[g])
        );

        // Sync-read memories and an accumulator that finishes one cycle after bias_add.
        always @(posedge clk) begin
            feat_data <= fmem[g][feat_addr[g][3:0]];
            wgt_data  <= wmem[g][wgt_addr[g][5:0]];
            bias_data <= bmem[g][bias_addr[g]];
            if (rst) mac_done <= 1'b0;
            else     mac_done <= mac_en[g] & mac_bias_add[g];
            if (mac_en[g]) begin
                if (mac_flush[g]) acc <= '0;
                else acc <= acc + 26'(lane_sum(mac_valid[g], mac_feature[g], mac_weight[g])
                                      + (mac_bias_add[g] ? int'($signed(mac_bias[g])) : 0));
            end
        end
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < c_N; k++) begin
            if (out_we[k]) begin
                wr_data[k][wr_cnt[k] % 256] <= out_data[k];
                wr_addr[k][wr_cnt[k] % 256] <= out_addr[k];
                wr_cyc[k][wr_cnt[k] % 256]  <= cyc;
                wr_cnt[k]                   <= wr_cnt[k] + 1;
            end
            if (done[k]) done_cnt[k] <= done_cnt[k] + 1;
        end
    end

    function automatic logic [7:0] requant(input int v, input int sh, input int relu);
        int r;
        r = v;
        if (relu != 0 && r < 0) r = 0;
        r = r >>> sh;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return 8'(r);
    endfunction

    function automatic logic [7:0] expected_out(input int k, input int n);
        int s = 0;
        int w = cfg_words(k);
        for (int i = 0; i < cfg_in(k); i++)
            s += byte_at(fmem[k][i/4], i % 4) * byte_at(wmem[k][n*w + i/4], i % 4);
        s += int'($signed(bmem[k][n]));
        return requant(s, cfg_shift(k), cfg_relu(k));
    endfunction

    function automatic bit outs_zero(input int k);
        return {busy[k], done[k], mac_en[k], mac_flush[k], mac_bias_add[k], out_we[k], mac_valid[k],
                feat_addr[k], wgt_addr[k], bias_addr[k], out_addr[k], out_data[k],
                mac_feature[k], mac_weight[k], mac_bias[k]} == '0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rnd_byte(input int mag);
        return 8'(int'($urandom_range(2*mag, 0)) - mag);
    endfunction

    // Bytes past IN_LEN in the last word are poisoned so a wrong lane mask shows up.
    task automatic poison(input int k);
        int w = cfg_words(k);
        for (int i = cfg_in(k); i < 4*w; i++) begin
            fmem[k][w-1][(i%4)*8 +: 8] = 8'h7F;
            for (int n = 0; n < cfg_out(k); n++) wmem[k][n*w + w-1][(i%4)*8 +: 8] = 8'h7F;
        end
    endtask

    task automatic fill_random(input int k, input int mag);
        for (int i = 0; i < 16; i++) fmem[k][i] = {rnd_byte(mag), rnd_byte(mag), rnd_byte(mag), rnd_byte(mag)};
        for (int i = 0; i < 64; i++) wmem[k][i] = {rnd_byte(mag), rnd_byte(mag), rnd_byte(mag), rnd_byte(mag)};
        for (int i = 0; i < 16; i++) bmem[k][i] = rnd_byte(mag);
        poison(k);
    endtask

    task automatic fill_const(input int k);
        for (int i = 0; i < 16; i++) fmem[k][i] = 32'h01010101;
        for (int i = 0; i < 64; i++) wmem[k][i] = 32'h02020202;
        for (int i = 0; i < 16; i++) bmem[k][i] = 8'd3;
        poison(k);
    endtask

    task automatic run_layer(input bit use_tbl, input logic [7:0] tbl_exp [c_N], input bit poke);
        int wb [c_N];
        int db [c_N];
        bit fin;
        for (int k = 0; k < c_N; k++) begin wb[k] = wr_cnt[k]; db[k] = done_cnt[k]; end
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < c_N; k++) check($sformatf("busy_after_start[%0d]", k), int'(busy[k]), 1);
        fin = 1'b0;
        for (int t = 0; t < 400 && !fin; t++) begin
            @(negedge clk);
            start = poke && (t == 4 || done[0]);
            fin = 1'b1;
            for (int k = 0; k < c_N; k++) if (busy[k] || done_cnt[k] == db[k]) fin = 1'b0;
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("layer_timeout", int'(fin), 1);
        for (int k = 0; k < c_N; k++) begin
            check($sformatf("write_count[%0d]", k), wr_cnt[k] - wb[k], cfg_out(k));
            check($sformatf("done_count[%0d]", k), done_cnt[k] - db[k], 1);
            for (int n = 0; n < cfg_out(k) && n < wr_cnt[k] - wb[k]; n++) begin
                int idx;
                logic [7:0] e;
                idx = (wb[k] + n) % 256;
                e = use_tbl ? tbl_exp[k] : expected_out(k, n);
                check($sformatf("out_addr[%0d][%0d]", k, n), int'(wr_addr[k][idx]), n);
                check($sformatf("out_data[%0d][%0d]", k, n), int'(wr_data[k][idx]), int'(e));
                if (n > 0)
                    check($sformatf("neuron_cycles[%0d][%0d]", k, n),
                          wr_cyc[k][idx] - wr_cyc[k][(idx + 255) % 256], cfg_words(k) + cfg_lat(k) + 5);
            end
        end
    endtask

    typedef struct packed {
        logic [31:0] sum;
        logic [7:0]  e0;
        logic [7:0]  e1;
        logic [7:0]  e2;
    } vec_t;

    initial begin
        vec_t       tbl [12];
        logic [7:0] te [c_N];
        logic [7:0] none [c_N];
        int         db [c_N];
        bit         seen;

        tbl[0]  = '{32'sd300,     8'h7F, 8'h7F, 8'h02};
        tbl[1]  = '{-32'sd50,     8'h00, 8'hCE, 8'hFF};
        tbl[2]  = '{-32'sd300,    8'h00, 8'h80, 8'hFD};
        tbl[3]  = '{32'sd1000,    8'h7F, 8'h7F, 8'h07};
        tbl[4]  = '{-32'sd1000,   8'h00, 8'h80, 8'hF8};
        tbl[5]  = '{32'sd19,      8'h13, 8'h13, 8'h00};
        tbl[6]  = '{32'sd127,     8'h7F, 8'h7F, 8'h00};
        tbl[7]  = '{32'sd128,     8'h7F, 8'h7F, 8'h01};
        tbl[8]  = '{-32'sd128,    8'h00, 8'h80, 8'hFF};
        tbl[9]  = '{-32'sd129,    8'h00, 8'h80, 8'hFE};
        tbl[10] = '{32'sd100000,  8'h7F, 8'h7F, 8'h7F};
        tbl[11] = '{-32'sd100000, 8'h00, 8'h80, 8'h80};

        none    = '{default: 8'h00};
        rst     = 1'b1;
        start   = 1'b0;
        ovr_en  = 1'b0;
        ovr_val = '0;
        for (int k = 0; k < c_N; k++) fill_random(k, 6);
        repeat (3) @(negedge clk);
        for (int k = 0; k < c_N; k++) check($sformatf("reset_outputs_zero[%0d]", k), int'(outs_zero(k)), 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Features 1, weights 2, bias 3.
        for (int k = 0; k < c_N; k++) fill_const(k);
        run_layer(1'b0, none, 1'b0);
        check("ones_n0", int'(wr_data[0][(wr_cnt[0] + 254) % 256]), 19);
        check("ones_n1", int'(wr_data[0][(wr_cnt[0] + 255) % 256]), 19);
        check("ones_6lane", int'(wr_data[1][(wr_cnt[1] + 255) % 256]), 15);

        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < c_N; k++) fill_random(k, (k == 2) ? 100 : 6);
            run_layer(1'b0, none, 1'b0);
        end

        ovr_en = 1'b1;
        for (int e = 0; e < 12; e++) begin
            ovr_val = tbl[e].sum[25:0];
            te[0] = tbl[e].e0;
            te[1] = tbl[e].e1;
            te[2] = tbl[e].e2;
            run_layer(1'b1, te, 1'b0);
        end
        ovr_en = 1'b0;

        // Starts while busy and during the first done pulse must be ignored.
        for (int k = 0; k < c_N; k++) fill_random(k, 6);
        run_layer(1'b0, none, 1'b1);

        // Reset during the feed phase of neuron 1 of the 3-neuron instance.
        for (int k = 0; k < c_N; k++) begin fill_random(k, (k == 2) ? 100 : 6); db[k] = done_cnt[k]; end
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            seen = out_we[1];
        end
        check("reset_reach_write", int'(seen), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int k = 0; k < c_N; k++) check($sformatf("midreset_zero[%0d]", k), int'(outs_zero(k)), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        for (int k = 0; k < c_N; k++) begin
            check($sformatf("midreset_no_done[%0d]", k), done_cnt[k] - db[k], 0);
            check($sformatf("midreset_idle[%0d]", k), int'(busy[k]), 0);
        end
        run_layer(1'b0, none, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
